// File: rtl/sobel_gradient_pkg.sv
// rtl/sobel_gradient_pkg.sv - shared types, widths and frame constants for the Sobel gradient pipeline
package sobel_gradient_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 8;
  localparam int DEF_IMG_HEIGHT = 8;

  localparam int GRAD_W     = DEF_DATA_WIDTH + 3;
  localparam int ABS_W      = DEF_DATA_WIDTH + 2;
  localparam int PIX_MAX    = (2 ** DEF_DATA_WIDTH) - 1;
  localparam int OUT_PIXELS = (DEF_IMG_WIDTH - 2) * (DEF_IMG_HEIGHT - 2);

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  // A one-output frame still needs a 1-bit counter register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_abs_diff.sv
// rtl/sobel_abs_diff.sv - registered absolute difference of two unsigned Sobel partial sums
module sobel_abs_diff
  import sobel_gradient_pkg::*;
#(
  parameter int AW = ABS_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] abs_out
);

  logic [AW-1:0] abs_next;

  // Ordering the operands first keeps the result unsigned and full width.
  always_comb begin
    abs_next = '0;
    if (a >= b) abs_next = a - b;
    else        abs_next = b - a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    abs_out <= '0;
    else if (load) abs_out <= abs_next;
  end

endmodule

// File: rtl/sobel_gradient.sv
// rtl/sobel_gradient.sv - three-stage Sobel magnitude, edge threshold and frame output counting
module sobel_gradient
  import sobel_gradient_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] row0_0,
  input  logic [DATA_WIDTH-1:0] row0_1,
  input  logic [DATA_WIDTH-1:0] row0_2,
  input  logic [DATA_WIDTH-1:0] row1_0,
  input  logic [DATA_WIDTH-1:0] row1_1,
  input  logic [DATA_WIDTH-1:0] row1_2,
  input  logic [DATA_WIDTH-1:0] row2_0,
  input  logic [DATA_WIDTH-1:0] row2_1,
  input  logic [DATA_WIDTH-1:0] row2_2,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] mag_out,
  output logic                  edge_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int A_W   = DATA_WIDTH + 2;
  localparam int S_W   = DATA_WIDTH + 3;
  localparam int N_OUT = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int CNT_W = cnt_width(N_OUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OUT - 1);

  // row1_1 has zero weight in both kernels.
  function automatic logic [A_W-1:0] psum(input logic [DATA_WIDTH-1:0] p,
                                          input logic [DATA_WIDTH-1:0] q,
                                          input logic [DATA_WIDTH-1:0] r);
    return A_W'(p) + (A_W'(q) << 1) + A_W'(r);
  endfunction

  logic [A_W-1:0] s1_xp, s1_xn, s1_yp, s1_yn;
  logic           s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_xp    <= '0;
      s1_xn    <= '0;
      s1_yp    <= '0;
      s1_yn    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_xp <= psum(row0_2, row1_2, row2_2);
        s1_xn <= psum(row0_0, row1_0, row2_0);
        s1_yp <= psum(row2_0, row2_1, row2_2);
        s1_yn <= psum(row0_0, row0_1, row0_2);
      end
    end
  end

  logic [A_W-1:0] s2_abs_x, s2_abs_y;
  logic           s2_valid;

  sobel_abs_diff #(.AW(A_W)) u_abs_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s1_valid),
    .a       (s1_xp),
    .b       (s1_xn),
    .abs_out (s2_abs_x)
  );

  sobel_abs_diff #(.AW(A_W)) u_abs_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s1_valid),
    .a       (s1_yp),
    .b       (s1_yn),
    .abs_out (s2_abs_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_valid <= 1'b0;
    else        s2_valid <= s1_valid;
  end

  logic [S_W-1:0]        sum;
  logic [DATA_WIDTH-1:0] mag_next;
  logic                  edge_next;

  always_comb begin
    sum       = {1'b0, s2_abs_x} + {1'b0, s2_abs_y};
    mag_next  = sum[DATA_WIDTH-1:0];
    if (|sum[S_W-1:DATA_WIDTH]) mag_next = '1;
    edge_next = (mag_next >= threshold);
  end

  logic [CNT_W-1:0] out_cnt;

  // frame_done is registered alongside valid_out so the two always coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_out    <= '0;
      edge_out   <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      out_cnt    <= '0;
    end else begin
      valid_out  <= s2_valid;
      frame_done <= 1'b0;
      if (s2_valid) begin
        mag_out  <= mag_next;
        edge_out <= edge_next;
        if (out_cnt == LAST_CNT) begin
          out_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

endmodule
